// File: rtl/lbist_ctrl.sv
// lbist_ctrl: autonomous logic-BIST controller for multi-chain mux-D scan designs.
// A PRPG LFSR feeds the scan-chain heads while scan_en is high. The controller runs
// a programmable number of shift/capture patterns, then unloads the chains one final
// time. The chain tails are compacted into a MISR, and the MISR value is the
// signature.
//
// Ports:
//   CK           clock, rising edge
//   RN           asynchronous active-low reset
//   start        single-cycle request, sampled only in IDLE
//   abort        return to IDLE from any busy state (priority over start)
//   num_patterns pattern count, latched with an accepted start
//   scan_en      drives SE of every chain
//   scan_in      chain heads, bit i -> chain i SI
//   scan_out     chain tails, bit i <- chain i last flop
//   busy         high in SHIFT, CAPTURE, UNLOAD
//   done         completion flag, held in IDLE until the next accepted start
//   signature    current MISR value
module lbist_ctrl #(
   parameter int unsigned          N_CHAINS  = 4,
   parameter int unsigned          CHAIN_LEN = 8,
   parameter int unsigned          PRPG_W    = 16,
   parameter logic [PRPG_W-1:0]    PRPG_SEED = 16'hACE1,
   parameter logic [PRPG_W-1:0]    PRPG_POLY = 16'hB400,
   parameter int unsigned          MISR_W    = 16,
   parameter logic [MISR_W-1:0]    MISR_POLY = 16'hB400,
   parameter int unsigned          PAT_W     = 16
) (
   input  logic                CK,
   input  logic                RN,
   input  logic                start,
   input  logic                abort,
   input  logic [PAT_W-1:0]    num_patterns,
   output logic                scan_en,
   output logic [N_CHAINS-1:0] scan_in,
   input  logic [N_CHAINS-1:0] scan_out,
   output logic                busy,
   output logic                done,
   output logic [MISR_W-1:0]   signature
);

   localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StCapture, StUnload} state_e;

   state_e            state_q, state_d;
   logic [PRPG_W-1:0] prpg_q, prpg_d;
   logic [MISR_W-1:0] misr_q, misr_d;
   logic [PAT_W-1:0]  pat_cnt_q, pat_cnt_d;
   logic [PAT_W-1:0]  num_pat_q, num_pat_d;
   logic [CntW-1:0]   shift_cnt_q, shift_cnt_d;
   logic              done_q, done_d;

   logic [PRPG_W-1:0] prpg_step;
   logic [MISR_W-1:0] misr_step;
   logic [PAT_W-1:0]  pat_next;
   logic              shift_last;

   assign prpg_step  = {prpg_q[PRPG_W-2:0], 1'b0} ^ (prpg_q[PRPG_W-1] ? PRPG_POLY : '0);
   assign misr_step  = ({misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? MISR_POLY : '0))
                       ^ MISR_W'(scan_out);
   assign pat_next   = pat_cnt_q + PAT_W'(1);
   assign shift_last = (shift_cnt_q == CntW'(CHAIN_LEN - 1));

   always_comb begin
      state_d     = state_q;
      prpg_d      = prpg_q;
      misr_d      = misr_q;
      pat_cnt_d   = pat_cnt_q;
      num_pat_d   = num_pat_q;
      shift_cnt_d = shift_cnt_q;
      done_d      = done_q;

      if (abort && (state_q != StIdle)) begin
         // Signature is left frozen at its value when the abort was taken.
         state_d     = StIdle;
         done_d      = 1'b0;
         pat_cnt_d   = '0;
         shift_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  misr_d = '0;
                  if (num_patterns != '0) begin
                     state_d     = StShift;
                     prpg_d      = PRPG_SEED;
                     pat_cnt_d   = '0;
                     shift_cnt_d = '0;
                     num_pat_d   = num_patterns;
                     done_d      = 1'b0;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            StShift: begin
               prpg_d = prpg_step;
               // During pattern 0 the tails carry power-up contents, so they are not compacted.
               if (pat_cnt_q != '0) misr_d = misr_step;
               if (shift_last) begin
                  shift_cnt_d = '0;
                  state_d     = StCapture;
               end else begin
                  shift_cnt_d = shift_cnt_q + CntW'(1);
               end
            end
            StCapture: begin
               pat_cnt_d = pat_next;
               state_d   = (pat_next == num_pat_q) ? StUnload : StShift;
            end
            StUnload: begin
               misr_d = misr_step;
               if (shift_last) begin
                  shift_cnt_d = '0;
                  state_d     = StIdle;
                  done_d      = 1'b1;
               end else begin
                  shift_cnt_d = shift_cnt_q + CntW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q     <= StIdle;
         prpg_q      <= PRPG_SEED;
         misr_q      <= '0;
         pat_cnt_q   <= '0;
         num_pat_q   <= '0;
         shift_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prpg_q      <= prpg_d;
         misr_q      <= misr_d;
         pat_cnt_q   <= pat_cnt_d;
         num_pat_q   <= num_pat_d;
         shift_cnt_q <= shift_cnt_d;
         done_q      <= done_d;
      end
   end

   // All outputs are decoded from registered state only.
   assign scan_en   = (state_q == StShift) || (state_q == StUnload);
   assign scan_in   = (state_q == StShift) ? prpg_q[N_CHAINS-1:0] : '0;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign signature = misr_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// tb_lbist_ctrl: directed test of lbist_ctrl with default parameters. It surrounds
// the controller with a 4x8 scan-chain environment, and a reference model computes
// the golden MISR signature.
module tb_lbist_ctrl;

   logic        CK = 1'b0;
   logic        RN = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] num_patterns = 16'h0;
   logic        scan_en;
   logic [3:0]  scan_in;
   logic [3:0]  scan_out;
   logic        busy;
   logic        done;
   logic [15:0] signature;

   int checks = 0;
   int errors = 0;

   // Environment: four 8-flop mux-D chains. SE high shifts; SE low captures a fixed mixing function.
   logic [7:0] env_ch [4];
   logic       use_env = 1'b0;
   logic [3:0] flip = 4'h0;

   always #5 CK = ~CK;

   lbist_ctrl dut (
      .CK           (CK),
      .RN           (RN),
      .start        (start),
      .abort        (abort),
      .num_patterns (num_patterns),
      .scan_en      (scan_en),
      .scan_in      (scan_in),
      .scan_out     (scan_out),
      .busy         (busy),
      .done         (done),
      .signature    (signature)
   );

   always @(posedge CK) begin
      for (int i = 0; i < 4; i++) begin
         if (scan_en) begin
            env_ch[i] <= {env_ch[i][6:0], scan_in[i]};
         end else begin
            for (int j = 0; j < 8; j++)
               env_ch[i][j] <= env_ch[i][j] ^ env_ch[(i+1)%4][(j+3)%8];
         end
      end
   end

   assign scan_out = use_env ? ({env_ch[3][7], env_ch[2][7], env_ch[1][7], env_ch[0][7]} ^ flip)
                             : 4'h0;

   function automatic logic [15:0] prpg_step(input logic [15:0] p);
      return {p[14:0], 1'b0} ^ (p[15] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [3:0] d);
      return ({m[14:0], 1'b0} ^ (m[15] ? 16'hB400 : 16'h0000)) ^ {12'h000, d};
   endfunction

   // Reference run of n patterns. flip_k selects an unload cycle whose tails are inverted by flip_m.
   function automatic logic [15:0] golden(input int n, input int flip_k, input logic [3:0] flip_m);
      logic [7:0]  ch [4];
      logic [7:0]  nx [4];
      logic [15:0] p = 16'hACE1;
      logic [15:0] m = 16'h0000;
      logic [3:0]  t;
      logic [3:0]  si;
      for (int i = 0; i < 4; i++) ch[i] = 8'h00;
      for (int pt = 0; pt < n; pt++) begin
         for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) t[i] = ch[i][7];
            si = p[3:0];
            if (pt != 0) m = misr_step(m, t);
            for (int i = 0; i < 4; i++) ch[i] = {ch[i][6:0], si[i]};
            p = prpg_step(p);
         end
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++)
               nx[i][j] = ch[i][j] ^ ch[(i+1)%4][(j+3)%8];
         for (int i = 0; i < 4; i++) ch[i] = nx[i];
      end
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 4; i++) t[i] = ch[i][7];
         if (c == flip_k) t = t ^ flip_m;
         m = misr_step(m, t);
         for (int i = 0; i < 4; i++) ch[i] = {ch[i][6:0], 1'b0};
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] n);
      @(posedge CK);
      #1 start = 1'b1;
      num_patterns = n;
      @(posedge CK);
      #1 start = 1'b0;
   endtask

   // Counts cycles after the start edge until done is seen, logging scan_en-low cycles.
   int cyc;
   int lows;
   int low_at [8];
   int flip_cyc = 0;
   logic [3:0] flip_m = 4'h0;
   int busy_start_cyc = 0;

   task automatic wait_done(input int budget);
      cyc  = 0;
      lows = 0;
      for (int i = 0; i < 8; i++) low_at[i] = 0;
      while (cyc < budget) begin
         @(negedge CK);
         cyc++;
         flip = (cyc == flip_cyc) ? flip_m : 4'h0;
         if (cyc == busy_start_cyc) begin
            start        = 1'b1;
            num_patterns = 16'd1;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) break;
         if (scan_en === 1'b0) begin
            if (lows < 8) low_at[lows] = cyc;
            lows++;
         end
      end
      flip  = 4'h0;
      start = 1'b0;
   endtask

   logic [15:0] g5;
   logic [15:0] g5_flip;
   logic [15:0] p;

   initial begin
      g5      = golden(5, -1, 4'h0);
      g5_flip = golden(5, 3, 4'h4);

      // Reset state
      repeat (3) @(negedge CK);
      chk("rst_scan_en", scan_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sig", signature, 16'h0000);
      chk("rst_scan_in", scan_in, 4'h0);
      RN = 1'b1;

      // Three patterns with tails tied low
      do_start(16'd3);
      wait_done(200);
      chk("p3_done_cycle", cyc, 36);
      chk("p3_low_count", lows, 3);
      chk("p3_low0", low_at[0], 9);
      chk("p3_low1", low_at[1], 18);
      chk("p3_low2", low_at[2], 27);
      chk("p3_sig", signature, 16'h0000);
      chk("p3_busy_idle", busy, 1'b0);

      // PRPG sequence on the chain heads
      do_start(16'd1);
      p = 16'hACE1;
      for (int c = 0; c < 8; c++) begin
         @(negedge CK);
         chk("prpg_model", scan_in, p[3:0]);
         if (c == 0) chk("prpg_c0", scan_in, 4'h1);
         if (c == 1) chk("prpg_c1", scan_in, 4'h2);
         p = prpg_step(p);
      end
      wait_done(200);
      chk("p1_done_rest", cyc, 10);

      // Loopback run against the golden signature, then a faulted tail bit on unload cycle 3
      use_env = 1'b1;
      do_start(16'd5);
      wait_done(200);
      chk("p5_done_cycle", cyc, 54);
      chk("p5_sig", signature, g5);
      repeat (4) @(negedge CK);
      chk("p5_sig_idle", signature, g5);
      flip_cyc = 49;
      flip_m   = 4'h4;
      do_start(16'd5);
      wait_done(200);
      flip_cyc = 0;
      chk("flip_sig", signature, g5_flip);
      chk("flip_differs", (signature != g5), 1'b1);

      // A second start while busy leaves the timing unchanged
      use_env        = 1'b0;
      busy_start_cyc = 4;
      do_start(16'd2);
      wait_done(200);
      busy_start_cyc = 0;
      chk("busy_start_cycle", cyc, 27);
      chk("busy_start_lows", lows, 2);

      // Abort in the pattern-2 capture cycle
      use_env = 1'b1;
      do_start(16'd5);
      repeat (27) @(negedge CK);
      chk("abort_in_capture_se", scan_en, 1'b0);
      chk("abort_in_capture_busy", busy, 1'b1);
      abort = 1'b1;
      @(negedge CK);
      abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_scan_en", scan_en, 1'b0);

      // Zero patterns: immediate done and cleared signature
      do_start(16'd0);
      @(negedge CK);
      chk("p0_done", done, 1'b1);
      chk("p0_sig", signature, 16'h0000);
      chk("p0_busy", busy, 1'b0);
      @(negedge CK);
      chk("p0_scan_en", scan_en, 1'b0);

      // A restart after the abort matches a clean run
      do_start(16'd5);
      wait_done(200);
      chk("after_abort_cycle", cyc, 54);
      chk("after_abort_sig", signature, g5);

      // Reset in mid-UNLOAD
      do_start(16'd5);
      repeat (49) @(negedge CK);
      RN = 1'b0;
      #1;
      chk("rn_scan_en", scan_en, 1'b0);
      chk("rn_busy", busy, 1'b0);
      chk("rn_done", done, 1'b0);
      chk("rn_sig", signature, 16'h0000);
      chk("rn_scan_in", scan_in, 4'h0);
      @(negedge CK);
      RN = 1'b1;
      do_start(16'd5);
      wait_done(200);
      chk("after_rn_cycle", cyc, 54);
      chk("after_rn_sig", signature, g5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
